// File: rtl/dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// dispatch_ctrl
// Two-slot in-order dispatch stage. Holds an instruction pair (A older,
// B younger), assigns each one to a free reservation-station port of its
// class, tags it with a ROB entry and registers the grants toward the RS.
//
// RS port index map (rs_free / rs_valid / rs_data / rs_entry slices):
//   5 = complex0, 4 = complex1, 3 = simple0, 2 = simple1, 1 = fp0, 0 = fp1
//
// Optional feature macro: DISPATCH_SIMPLE_OVERFLOW_EN
//   defined   : simple instructions may fall back to complex1, then complex0
//   undefined : simple instructions use only simple1 / simple0
// -----------------------------------------------------------------------------
module dispatch_ctrl #(
   parameter  int DATA_W    = 114,
   parameter  int ROB_DEPTH = 16,
   localparam int ROB_AW    = $clog2(ROB_DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      inst_a_data,
   input  logic [DATA_W-1:0]      inst_b_data,
   input  logic [1:0]             inst_a_ctrl,
   input  logic [1:0]             inst_b_ctrl,
   input  logic [5:0]             rs_free,
   input  logic [1:0]             rob_retire_cnt,
   output logic [6*DATA_W-1:0]    rs_data,
   output logic [6*ROB_AW-1:0]    rs_entry,
   output logic [5:0]             rs_valid,
   output logic [ROB_AW-1:0]      rob_tail,
   output logic [ROB_AW:0]        rob_count,
   output logic                   stall_a,
   output logic                   stall_b
);

   // Instruction class carried in the 2-bit ctrl field.
   typedef enum logic [1:0] {
      CLS_NOP     = 2'b00,
      CLS_COMPLEX = 2'b01,
      CLS_FP      = 2'b10,
      CLS_SIMPLE  = 2'b11
   } cls_e;

   localparam int P_CPLX0 = 5;
   localparam int P_CPLX1 = 4;
   localparam int P_SIMP0 = 3;
   localparam int P_SIMP1 = 2;
   localparam int P_FP0   = 1;
   localparam int P_FP1   = 0;

   localparam logic [ROB_AW:0] L_ROB_FULL = (ROB_AW+1)'(ROB_DEPTH);

   // ---------------------------------------------------------------- state
   logic                r_a_valid;
   cls_e                r_a_cls;
   logic [DATA_W-1:0]   r_a_data;
   logic                r_b_valid;
   cls_e                r_b_cls;
   logic [DATA_W-1:0]   r_b_data;

   logic [5:0]          r_rs_valid;
   logic [DATA_W-1:0]   r_rs_data  [6];
   logic [ROB_AW-1:0]   r_rs_entry [6];

   logic [ROB_AW-1:0]   r_rob_tail;
   logic [ROB_AW:0]     r_rob_count;

   // ------------------------------------------------------------ decisions
   logic [5:0]          w_free_eff;
   logic [5:0]          w_a_gnt;
   logic [5:0]          w_b_gnt;
   logic                w_a_disp;
   logic                w_b_disp;
   logic                w_b_elig;
   logic [ROB_AW:0]     w_rob_after_a;
   logic [1:0]          w_disp_cnt;
   logic [ROB_AW-1:0]   w_b_tag;
   logic                w_slots_empty;
   logic [ROB_AW:0]     w_rob_sum;
   logic [ROB_AW:0]     w_retire;
   logic [ROB_AW:0]     w_rob_next;

   // One-hot grant of the highest-priority free port for a class.
   function automatic logic [5:0] f_pick(input cls_e cls, input logic [5:0] free);
      logic [5:0] g;
      g = '0;
      case (cls)
         CLS_COMPLEX: begin
            if (free[P_CPLX1])      g[P_CPLX1] = 1'b1;
            else if (free[P_CPLX0]) g[P_CPLX0] = 1'b1;
         end
         CLS_FP: begin
            if (free[P_FP1])        g[P_FP1] = 1'b1;
            else if (free[P_FP0])   g[P_FP0] = 1'b1;
         end
         CLS_SIMPLE: begin
`ifdef DISPATCH_SIMPLE_OVERFLOW_EN
            if (free[P_SIMP1])      g[P_SIMP1] = 1'b1;
            else if (free[P_SIMP0]) g[P_SIMP0] = 1'b1;
            else if (free[P_CPLX1]) g[P_CPLX1] = 1'b1;
            else if (free[P_CPLX0]) g[P_CPLX0] = 1'b1;
`else
            if (free[P_SIMP1])      g[P_SIMP1] = 1'b1;
            else if (free[P_SIMP0]) g[P_SIMP0] = 1'b1;
`endif
         end
         default: g = '0;
      endcase
      return g;
   endfunction

   // In-order allocation: A first, then B from the ports A left behind.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      w_free_eff = rs_free & ~r_rs_valid;
      w_a_gnt    = '0;
      w_b_gnt    = '0;

      if (r_a_valid && (r_rob_count < L_ROB_FULL))
         w_a_gnt = f_pick(r_a_cls, w_free_eff);
      w_a_disp = |w_a_gnt;

      w_rob_after_a = r_rob_count + (ROB_AW+1)'(w_a_disp);
      w_b_elig      = r_b_valid && (!r_a_valid || w_a_disp) && (w_rob_after_a < L_ROB_FULL);
      if (w_b_elig)
         w_b_gnt = f_pick(r_b_cls, w_free_eff & ~w_a_gnt);
      w_b_disp = |w_b_gnt;

      w_disp_cnt    = {1'b0, w_a_disp} + {1'b0, w_b_disp};
      w_b_tag       = r_rob_tail + ROB_AW'(w_a_disp);
      w_slots_empty = (!r_a_valid || w_a_disp) && (!r_b_valid || w_b_disp);
   end

   // Next ROB occupancy: add dispatches, remove retirements, floor at zero.
   always_comb begin
      w_rob_sum  = r_rob_count + (ROB_AW+1)'(w_disp_cnt);
      w_retire   = (ROB_AW+1)'(rob_retire_cnt);
      w_rob_next = (w_rob_sum > w_retire) ? (w_rob_sum - w_retire) : '0;
   end

   // Slot A/B holding: load a new pair, shift B forward, or keep stalled ones.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
      if (rst || flush) begin
         r_a_valid <= 1'b0;
         r_b_valid <= 1'b0;
         r_a_cls   <= CLS_NOP;
         r_b_cls   <= CLS_NOP;
      end else if (w_slots_empty) begin
         r_a_valid <= in_valid && (inst_a_ctrl != 2'b00);
         r_b_valid <= in_valid && (inst_b_ctrl != 2'b00);
         r_a_cls   <= cls_e'(inst_a_ctrl);
         r_b_cls   <= cls_e'(inst_b_ctrl);
         r_a_data  <= inst_a_data;
         r_b_data  <= inst_b_data;
      end else if (w_a_disp) begin
         r_a_valid <= r_b_valid;
         r_a_cls   <= r_b_cls;
         r_a_data  <= r_b_data;
         r_b_valid <= 1'b0;
      end
   end

   // Registered grants toward the reservation stations (valid for one cycle).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rs_valid <= '0;
         // NOTE: the six grant slices are ordinary flops, not a RAM, so clearing them on reset is cheap and keeps outputs defined.
         for (int i = 0; i < 6; i++) begin
            r_rs_data[i]  <= '0;
            r_rs_entry[i] <= '0;
         end
      end else if (flush) begin
         r_rs_valid <= '0;
      end else begin
         r_rs_valid <= w_a_gnt | w_b_gnt;
         for (int i = 0; i < 6; i++) begin
            if (w_a_gnt[i]) begin
               r_rs_data[i]  <= r_a_data;
               r_rs_entry[i] <= r_rob_tail;
            end else if (w_b_gnt[i]) begin
               r_rs_data[i]  <= r_b_data;
               r_rs_entry[i] <= w_b_tag;
            end
         end
      end
   end

   // ROB allocation pointer and occupancy.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rob_tail  <= '0;
         r_rob_count <= '0;
      end else begin
         r_rob_tail  <= r_rob_tail + ROB_AW'(w_disp_cnt);
         r_rob_count <= w_rob_next;
      end
   end

   // ------------------------------------------------------------- outputs
   assign in_ready  = w_slots_empty;
   assign stall_a   = r_a_valid & ~w_a_disp;
   assign stall_b   = r_b_valid & ~w_b_disp;
   assign rs_valid  = r_rs_valid;
   assign rob_tail  = r_rob_tail;
   assign rob_count = r_rob_count;

   for (genvar g = 0; g < 6; g++) begin : g_slice
      assign rs_data[g*DATA_W +: DATA_W] = r_rs_data[g];
      assign rs_entry[g*ROB_AW +: ROB_AW] = r_rs_entry[g];
   end

endmodule
